// File: rtl/axis_header_prepend_pkg.sv
// Shared types and reset constants for the header/payload frame merger.
package axis_header_prepend_pkg;

  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned MAX_HEADER_WORDS_DEF = 4;
  localparam int unsigned CNTR_WIDTH_DEF = 32;

  typedef enum logic {
    HDR = 1'b0,
    PLD = 1'b1
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } axis_word_t;

  localparam state_t     STATE_RST = HDR;
  localparam axis_word_t WORD_RST  = '0;
  localparam logic       VALID_RST = 1'b0;
  localparam logic       ERR_RST   = 1'b0;

endpackage

// File: rtl/axis_header_prepend_if.sv
// AxiStream bundle shared by the header, payload and merged streams.
interface axis_header_prepend_if;
  import axis_header_prepend_pkg::*;

  logic [DATA_WIDTH-1:0] data;
  logic                  last;
  logic                  valid;
  logic                  ready;

  modport master (output data, output last, output valid, input ready);
  modport slave  (input data, input last, input valid, output ready);

endinterface

// File: rtl/axis_out_reg.sv
// One-entry AxiStream output register; accepts whenever its slot is free or draining.
module axis_out_reg
  import axis_header_prepend_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  axis_word_t in_word_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output axis_word_t out_word_o,
  output logic       out_valid_o,
  input  logic       out_ready_i
);

  axis_word_t word_q, word_d;
  logic       valid_q, valid_d;
  logic       out_free;

  assign out_free = !valid_q || out_ready_i;

  // Load on a free slot; otherwise hold the word stable for downstream.
  always_comb begin
    word_d  = word_q;
    valid_d = valid_q;
    if (out_free) begin
      valid_d = in_valid_i;
      if (in_valid_i) begin
        word_d = in_word_i;
      end
    end
  end

  // Output register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q  <= WORD_RST;
      valid_q <= VALID_RST;
    end else begin
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign in_ready_o  = out_free;
  assign out_word_o  = word_q;
  assign out_valid_o = valid_q;

endmodule

// File: rtl/axis_header_prepend.sv
// Merges a header stream and a payload stream into one frame stream: header words first, then payload.
module axis_header_prepend
  import axis_header_prepend_pkg::*;
#(
  parameter int unsigned MAX_HEADER_WORDS = MAX_HEADER_WORDS_DEF,
  parameter int unsigned CNTR_WIDTH       = CNTR_WIDTH_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  axis_header_prepend_if.slave    headers,
  axis_header_prepend_if.slave    din,
  axis_header_prepend_if.master   dout,
  output logic [CNTR_WIDTH-1:0]   frame_cnt_o,
  output logic                    err_hdr_len_o
);

  localparam int unsigned HCNT_W = $clog2(MAX_HEADER_WORDS + 1);

  state_t                  state_q, state_d;
  logic [HCNT_W-1:0]       hdr_cnt_q, hdr_cnt_d;
  logic [CNTR_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;
  logic                    err_q, err_d;

  axis_word_t              in_word;
  logic                    in_valid;
  logic                    in_ready;
  axis_word_t              out_word;
  logic                    headers_ready_c;
  logic                    din_ready_c;
  logic                    hdr_xfer;
  logic                    pld_xfer;

  // Next-state, stream select and counter updates; readies depend only on state and the output slot.
  always_comb begin
    state_d         = state_q;
    hdr_cnt_d       = hdr_cnt_q;
    frame_cnt_d     = frame_cnt_q;
    err_d           = err_q;
    in_word         = WORD_RST;
    in_valid        = 1'b0;
    headers_ready_c = 1'b0;
    din_ready_c     = 1'b0;
    hdr_xfer        = 1'b0;
    pld_xfer        = 1'b0;

    case (state_q)
      HDR: begin
        headers_ready_c = in_ready;
        in_valid        = headers.valid;
        in_word.data    = headers.data;
        in_word.last    = 1'b0;
        hdr_xfer        = headers.valid && in_ready;
        if (hdr_xfer) begin
          if (hdr_cnt_q == HCNT_W'(MAX_HEADER_WORDS)) begin
            err_d = 1'b1;
          end else begin
            hdr_cnt_d = hdr_cnt_q + HCNT_W'(1);
          end
          if (headers.last) begin
            hdr_cnt_d = '0;
            state_d   = PLD;
          end
        end
      end
      PLD: begin
        din_ready_c  = in_ready;
        in_valid     = din.valid;
        in_word.data = din.data;
        in_word.last = din.last;
        pld_xfer     = din.valid && in_ready;
        if (pld_xfer && din.last) begin
          frame_cnt_d = frame_cnt_q + CNTR_WIDTH'(1);
          state_d     = HDR;
        end
      end
      default: begin
        state_d = HDR;
      end
    endcase
  end

  // State and counter registers; a reset drops any partial frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= STATE_RST;
      hdr_cnt_q   <= '0;
      frame_cnt_q <= '0;
      err_q       <= ERR_RST;
    end else begin
      state_q     <= state_d;
      hdr_cnt_q   <= hdr_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
    end
  end

  axis_out_reg u_out_reg (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_word_i   (in_word),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_word_o  (out_word),
    .out_valid_o (dout.valid),
    .out_ready_i (dout.ready)
  );

  assign headers.ready = headers_ready_c;
  assign din.ready     = din_ready_c;
  assign dout.data     = out_word.data;
  assign dout.last     = out_word.last;
  assign frame_cnt_o   = frame_cnt_q;
  assign err_hdr_len_o = err_q;

endmodule

// File: tb/tb_axis_header_prepend.sv
// Directed bench for axis_header_prepend: frame order, backpressure, header-length error, wrap, reset.
module tb_axis_header_prepend;
  import axis_header_prepend_pkg::*;

  localparam int unsigned MAXH = 4;
  localparam int unsigned CW   = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] frame_cnt;
  logic          err;

  axis_header_prepend_if hif ();
  axis_header_prepend_if dif ();
  axis_header_prepend_if oif ();

  axis_header_prepend #(
    .MAX_HEADER_WORDS (MAXH),
    .CNTR_WIDTH       (CW)
  ) u_dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .headers       (hif),
    .din           (dif),
    .dout          (oif),
    .frame_cnt_o   (frame_cnt),
    .err_hdr_len_o (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  axis_word_t    hq[$];
  axis_word_t    dq[$];
  axis_word_t    eq[$];
  logic [CW-1:0] fcq[$];

  int         cyc = 0;
  int         rdy_mode = 0;
  int         hx_cnt = 0;
  logic       err_exp = 1'b0;
  logic       in_pld = 1'b0;
  int         n_out = 0;
  int         first_out_cyc = -1;
  int         last_out_cyc = -1;
  int         first_hx_cyc = -1;
  int         din_xfers = 0;
  logic       prev_stall = 1'b0;
  axis_word_t prev_word = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic load_frame(input int nh, input logic [63:0] hbase, input int np,
                            input logic [63:0] pbase, input logic [CW-1:0] fc);
    axis_word_t w;
    for (int i = 0; i < nh; i++) begin
      w.data = hbase + 64'(i);
      w.last = (i == nh - 1);
      hq.push_back(w);
      w.last = 1'b0;
      eq.push_back(w);
    end
    for (int i = 0; i < np; i++) begin
      w.data = pbase + 64'(i);
      w.last = (i == np - 1);
      dq.push_back(w);
      eq.push_back(w);
    end
    fcq.push_back(fc);
  endtask

  // One clock: drive at negedge, sample 1 ns later, update the model after the posedge.
  task automatic step();
    logic       hx, dx;
    axis_word_t w;
    @(negedge clk);
    cyc++;
    hif.valid = (hq.size() > 0);
    if (hq.size() > 0) begin
      hif.data = hq[0].data;
      hif.last = hq[0].last;
    end
    dif.valid = (dq.size() > 0);
    if (dq.size() > 0) begin
      dif.data = dq[0].data;
      dif.last = dq[0].last;
    end
    case (rdy_mode)
      1:       oif.ready = (cyc % 2 == 0);
      2:       oif.ready = 1'($urandom_range(0, 1));
      default: oif.ready = 1'b1;
    endcase
    #1;
    check_eq("err_hdr_len", 64'(err), 64'(err_exp));
    if (hif.ready) check_eq("hdr_ready_phase", 64'(in_pld), 64'(0));
    if (dif.ready) check_eq("din_ready_phase", 64'(in_pld), 64'(1));
    if (prev_stall) begin
      check_eq("stall_valid", 64'(oif.valid), 64'(1));
      check_eq("stall_data", oif.data, prev_word.data);
      check_eq("stall_last", 64'(oif.last), 64'(prev_word.last));
    end
    if (oif.valid && oif.ready) begin
      if (eq.size() == 0) begin
        check_eq("extra_word", 64'(eq.size()), 64'(1));
      end else begin
        w = eq.pop_front();
        check_eq("dout_data", oif.data, w.data);
        check_eq("dout_last", 64'(oif.last), 64'(w.last));
        if (first_out_cyc < 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
        n_out++;
        if (w.last && fcq.size() > 0) begin
          check_eq("frame_cnt", 64'(frame_cnt), 64'(fcq.pop_front()));
        end
      end
    end
    prev_stall     = oif.valid && !oif.ready;
    prev_word.data = oif.data;
    prev_word.last = oif.last;
    hx = hif.valid && hif.ready;
    dx = dif.valid && dif.ready;
    if (hx && first_hx_cyc < 0) first_hx_cyc = cyc;
    @(posedge clk);
    if (hx) begin
      w = hq.pop_front();
      if (hx_cnt == int'(MAXH)) err_exp = 1'b1;
      hx_cnt++;
      if (w.last) begin
        hx_cnt = 0;
        in_pld = 1'b1;
      end
    end
    if (dx) begin
      w = dq.pop_front();
      din_xfers++;
      if (w.last) in_pld = 1'b0;
    end
  endtask

  task automatic run(input string tag, input int budget);
    int n = 0;
    while ((hq.size() + dq.size() + eq.size()) > 0 && n < budget) begin
      step();
      n++;
    end
    check_eq(tag, 64'(hq.size() + dq.size() + eq.size()), 64'(0));
  endtask

  task automatic start_test();
    first_out_cyc = -1;
    last_out_cyc  = -1;
    first_hx_cyc  = -1;
    n_out         = 0;
  endtask

  initial begin
    rst       = 1'b1;
    hif.valid = 1'b0;
    hif.data  = '0;
    hif.last  = 1'b0;
    dif.valid = 1'b0;
    dif.data  = '0;
    dif.last  = 1'b0;
    oif.ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid", 64'(oif.valid), 64'(0));
    check_eq("rst_data", oif.data, 64'(0));
    check_eq("rst_last", 64'(oif.last), 64'(0));
    check_eq("rst_frame_cnt", 64'(frame_cnt), 64'(0));
    check_eq("rst_err", 64'(err), 64'(0));
    check_eq("rst_hdr_ready", 64'(hif.ready), 64'(1));
    check_eq("rst_din_ready", 64'(dif.ready), 64'(0));
    rst = 1'b0;

    // Basic frame at full rate, both streams valid from the start.
    start_test();
    load_frame(2, 64'hA0, 3, 64'hB0, 2'd1);
    run("basic_drain", 50);
    check_eq("basic_words", 64'(n_out), 64'(5));
    check_eq("basic_span", 64'(last_out_cyc - first_out_cyc), 64'(4));
    check_eq("basic_latency", 64'(first_out_cyc - first_hx_cyc), 64'(1));
    check_eq("basic_frame_cnt", 64'(frame_cnt), 64'(1));

    // Longer header with payload already waiting.
    start_test();
    load_frame(3, 64'hC0, 2, 64'hD0, 2'd2);
    run("preload_drain", 50);
    check_eq("preload_words", 64'(n_out), 64'(5));

    // Backpressure: alternating, then random dout_ready.
    start_test();
    rdy_mode = 1;
    load_frame(2, 64'hA0, 3, 64'hB0, 2'd3);
    run("bp_toggle_drain", 100);
    check_eq("bp_toggle_words", 64'(n_out), 64'(5));
    rdy_mode = 2;
    load_frame(1, 64'h50, 1, 64'h60, 2'd0);
    load_frame(2, 64'h70, 4, 64'h80, 2'd1);
    run("bp_rand_drain", 200);
    rdy_mode = 0;

    // Over-long header: forwarded intact, error goes sticky.
    start_test();
    check_eq("err_before_long", 64'(err), 64'(0));
    load_frame(5, 64'hE0, 1, 64'hF0, 2'd2);
    run("long_drain", 50);
    check_eq("long_words", 64'(n_out), 64'(6));
    check_eq("long_err", 64'(err), 64'(1));
    load_frame(1, 64'h90, 1, 64'h91, 2'd3);
    run("after_long_drain", 50);
    check_eq("err_sticky", 64'(err), 64'(1));

    // Reset after two payload words of a frame.
    din_xfers = 0;
    load_frame(2, 64'h10, 4, 64'h20, 2'd0);
    begin
      int n = 0;
      while (din_xfers < 2 && n < 100) begin
        step();
        n++;
      end
    end
    check_eq("rst_mid_wait", 64'(din_xfers), 64'(2));
    @(negedge clk);
    rst = 1'b1;
    hif.valid = 1'b0;
    dif.valid = 1'b0;
    hq.delete();
    dq.delete();
    eq.delete();
    fcq.delete();
    hx_cnt     = 0;
    in_pld     = 1'b0;
    err_exp    = 1'b0;
    prev_stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_mid_valid", 64'(oif.valid), 64'(0));
    check_eq("rst_mid_frame_cnt", 64'(frame_cnt), 64'(0));
    check_eq("rst_mid_err", 64'(err), 64'(0));

    // Fresh frames back to back; counter wraps 1,2,3,0,1 with no bubbles.
    start_test();
    load_frame(2, 64'h100, 2, 64'h200, 2'd1);
    load_frame(2, 64'h110, 2, 64'h210, 2'd2);
    load_frame(2, 64'h120, 2, 64'h220, 2'd3);
    load_frame(2, 64'h130, 2, 64'h230, 2'd0);
    load_frame(2, 64'h140, 2, 64'h240, 2'd1);
    run("wrap_drain", 100);
    check_eq("wrap_words", 64'(n_out), 64'(20));
    check_eq("wrap_span", 64'(last_out_cyc - first_out_cyc), 64'(19));
    check_eq("wrap_frame_cnt", 64'(frame_cnt), 64'(1));

    repeat (2) step();
    check_eq("idle_valid", 64'(oif.valid), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
